// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// Ownership is granted in bounded bursts, and no write is issued into a full FIFO.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         w_data,
  input  logic                          full,
  input  logic                          overflow,
  output logic                          busy,
  output logic                          err,
  output logic [15:0]                   total_writes
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [OW-1:0]   owner, owner_nxt;
  logic [OW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [OW-1:0]   winner, owner_inc;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            grant;
  logic            found;
  int              idx;

  // First requester at or after rr_ptr, scanning in circular order.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  assign owner_inc = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);

  // Holding rst forces the write side quiet, even when the FSM state is BURST.
  assign grant = (state == BURST) && req[owner] && !full && !rst;
  assign wr_en = grant;
  assign busy  = (state == BURST);

  always_comb begin
    gnt    = '0;
    w_data = '0;
    if (grant) begin
      gnt[owner] = 1'b1;
      w_data     = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: every output of this block is assigned a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = BURST;
          owner_nxt = winner;
          cnt_nxt   = '0;
        end
      end
      BURST: begin
        // A dropped request takes priority over a full FIFO and ends the burst.
        if (!req[owner] || (grant && cnt == CW'(MAX_BURST - 1))) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = owner_inc;
          cnt_nxt    = '0;
        end else if (grant) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
      err          <= 1'b0;
      total_writes <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      cnt    <= cnt_nxt;
      err    <= err | overflow;
      if (grant) total_writes <= total_writes + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: it models the requesters and a 16-deep FIFO and compares cycle traces against hand-written expectations.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic              full = 1'b0;
  logic              overflow = 1'b0;
  logic [N-1:0]      gnt;
  logic              wr_en;
  logic [DW-1:0]     w_data;
  logic              busy;
  logic              err;
  logic [15:0]       total_writes;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .wr_en(wr_en), .w_data(w_data), .full(full), .overflow(overflow),
    .busy(busy), .err(err), .total_writes(total_writes)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic         b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] src_q[N][$];
  logic [7:0] shadow_q[N][$];
  logic [7:0] fifo_q[$];
  logic [7:0] exp_fifo_q[$];
  int         n_total = 0;
  int         n_bad = 0;
  bit         auto_drain = 1'b1;
  bit         ovf_force = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i] = (src_q[i].size() > 0);
      req_data[i*DW +: DW] = req[i] ? src_q[i][0] : 8'h00;
    end
    full = (fifo_q.size() >= 16);
  endtask

  task automatic load(input int i, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      src_q[i].push_back(base + 8'(k));
      shadow_q[i].push_back(base + 8'(k));
    end
    drive_inputs();
  endtask

  // '.' idle, 'S' busy without grant, digit = grant to that requester.
  task automatic push_trace(input string s);
    for (int k = 0; k < s.len(); k++) begin
      byte  c;
      exp_t e;
      int   r;
      c   = s[k];
      e.g = '0;
      e.b = (c != ".");
      if (c >= "0" && c <= "3") begin
        r = c - "0";
        e.g[r] = 1'b1;
        exp_fifo_q.push_back(shadow_q[r].pop_front());
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic drain_one();
    logic [7:0] w;
    w = fifo_q.pop_front();
    if (exp_fifo_q.size() == 0) check("fifo_extra", 1, 0);
    else check("fifo_data", w, exp_fifo_q.pop_front());
  endtask

  task automatic step();
    exp_t         e;
    logic [7:0]   ed;
    logic [N-1:0] sg;
    logic         swe;
    logic [7:0]   swd;
    logic         wrote_full;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      ed = 8'h00;
      for (int i = 0; i < N; i++)
        if (e.g[i] && src_q[i].size() > 0) ed = src_q[i][0];
      check("gnt", gnt, e.g);
      check("busy", busy, e.b);
      check("wr_en", wr_en, |e.g);
      check("w_data", w_data, ed);
    end
    sg = gnt; swe = wr_en; swd = w_data;
    @(posedge clk);
    #1;
    wrote_full = 1'b0;
    if (swe) begin
      wrote_full = (fifo_q.size() >= 16);
      check("no_wr_full", wrote_full, 0);
      fifo_q.push_back(swd);
    end
    for (int i = 0; i < N; i++)
      if (sg[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    overflow = ovf_force | wrote_full;
    if (auto_drain && fifo_q.size() > 0) drain_one();
    drive_inputs();
  endtask

  task automatic run();
    while (exp_q.size() > 0) step();
  endtask

  task automatic finish_drain();
    for (int k = 0; k < 40 && fifo_q.size() > 0; k++) step();
    check("drained", fifo_q.size(), 0);
    check("exp_left", exp_fifo_q.size(), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    push_trace("..");
    run();
    check("rst_err", err, 0);
    check("rst_total", total_writes, 0);
    rst = 1'b0;

    // Single requester, 6 words: burst of 4, then a burst of 2
    load(0, 6, 8'h40);
    push_trace(".0000.00S.");
    run();
    check("t1_total", total_writes, 6);
    finish_drain();

    // All requesters pending: rotation 0,1,2,3,0
    pulse_reset();
    load(0, 5, 8'h00);
    load(1, 4, 8'h10);
    load(2, 4, 8'h20);
    load(3, 4, 8'h30);
    push_trace(".0000.1111.2222.3333.0S.");
    run();
    check("t2_total", total_writes, 17);
    finish_drain();

    // FIFO full stall; one read releases exactly one grant
    auto_drain = 1'b0;
    for (int k = 0; k < 16; k++) begin
      fifo_q.push_back(8'hA0 + 8'(k));
      exp_fifo_q.push_back(8'hA0 + 8'(k));
    end
    load(1, 2, 8'hB0);
    push_trace(".SSSS");
    run();
    drain_one();
    drive_inputs();
    push_trace("1S");
    run();
    auto_drain = 1'b1;
    drain_one();
    drive_inputs();
    push_trace("1S.");
    run();
    finish_drain();
    check("t3_ovf", overflow, 0);
    check("t3_err", err, 0);

    // Owner 2 drops early; the pointer moves to 3 ahead of 0
    load(2, 2, 8'h50);
    load(0, 1, 8'h60);
    load(3, 1, 8'h70);
    push_trace(".22S.3S.0S.");
    run();
    finish_drain();

    // Reset in the middle of a burst (owner 2, two words written)
    load(2, 4, 8'h80);
    push_trace(".22S");
    for (int k = 0; k < 3; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_total_rst", total_writes, 0);
    load(0, 1, 8'h90);
    load(1, 1, 8'h91);
    load(3, 1, 8'h93);
    push_trace(".0S.1S.22S.3S.");
    run();
    check("t5_total", total_writes, 5);
    finish_drain();

    // Sticky err from a single-cycle overflow
    check("t6_err_pre", err, 0);
    ovf_force = 1'b1;
    overflow  = 1'b1;
    push_trace(".");
    step();
    ovf_force = 1'b0;
    overflow  = 1'b0;
    check("t6_err_set", err, 1);
    load(1, 3, 8'hC0);
    push_trace(".111S.");
    run();
    finish_drain();
    check("t6_err_hold", err, 1);
    pulse_reset();
    check("t6_err_clr", err, 0);
    check("t6_total_clr", total_writes, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
